// File: rtl/dsi_pattern_gen_pkg.sv
// dsi_pattern_gen_pkg: register map, pattern mode codes, FSM states and bar palette
package dsi_pattern_gen_pkg;

    localparam logic [3:0] REG_TEST_XSIZE  = 4'd0;
    localparam logic [3:0] REG_TEST_YSIZE  = 4'd1;
    localparam logic [3:0] REG_TEST_CTL    = 4'd2;
    localparam logic [3:0] REG_TEST_COLOR  = 4'd3;
    localparam logic [3:0] REG_TEST_STATUS = 4'd4;

    localparam logic [2:0] MODE_BAR     = 3'd0;
    localparam logic [2:0] MODE_HRAMP   = 3'd1;
    localparam logic [2:0] MODE_VRAMP   = 3'd2;
    localparam logic [2:0] MODE_CHECKER = 3'd3;
    localparam logic [2:0] MODE_SOLID   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE            = 2'd0,
        ST_WAIT_NEXT_FRAME = 2'd1,
        ST_VSYNC           = 2'd2,
        ST_IMAGE           = 2'd3
    } state_t;

    // Index 0 sits in the low 24 bits: red, green, blue, yellow, cyan, magenta, grey, black
    localparam logic [8*24-1:0] BAR_COLORS = {
        24'h000000, 24'h808080, 24'hFF00FF, 24'h00FFFF,
        24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000
    };

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        bar_color = BAR_COLORS[idx*24 +: 24];
    endfunction

endpackage

// File: rtl/dsi_pattern_pixel.sv
// dsi_pattern_pixel: combinational map from one lane's coordinates and frame config to RGB
module dsi_pattern_pixel
    import dsi_pattern_gen_pkg::*;
#(
    parameter int g_coord_width = 12
) (
    input  logic [g_coord_width-1:0] i_xs,
    input  logic [g_coord_width-1:0] i_x,
    input  logic [g_coord_width-1:0] i_y,
    input  logic [g_coord_width-1:0] i_xsize,
    input  logic [g_coord_width-1:0] i_ysize,
    input  logic [2:0]               i_mode,
    input  logic [3:0]               i_bar_shift,
    input  logic                     i_border_en,
    input  logic [23:0]              i_color,
    output logic [23:0]              o_rgb
);

    logic [g_coord_width-1:0] w_xsh;
    logic [g_coord_width-1:0] w_ysh;
    logic                     w_unused_sh;
    logic                     w_border;
    logic [23:0]              w_pat;

    assign w_xsh       = i_xs >> i_bar_shift;
    assign w_ysh       = i_y >> i_bar_shift;
    assign w_unused_sh = ^{w_xsh, w_ysh};

    // Border uses unscrolled coordinates so the frame outline stays fixed while content moves
    assign w_border = i_border_en && (i_x == '0 || i_y == '0 || i_x == i_xsize || i_y == i_ysize);

    always_comb begin
        w_pat = i_mode == MODE_BAR     ? bar_color(w_xsh[2:0]) :
                i_mode == MODE_HRAMP   ? {3{i_xs[7:0]}} :
                i_mode == MODE_VRAMP   ? {3{i_y[7:0]}} :
                i_mode == MODE_CHECKER ? {24{w_xsh[0] ^ w_ysh[0]}} :
                i_mode == MODE_SOLID   ? i_color : 24'h000000;
    end

    assign o_rgb = w_border ? 24'hFFFFFF : w_pat;

endmodule

// File: rtl/dsi_pattern_gen.sv
// dsi_pattern_gen: multi-mode test image source with host registers and a pixel-FIFO style read port
module dsi_pattern_gen
    import dsi_pattern_gen_pkg::*;
#(
    parameter int g_pixels_per_clock = 1,
    parameter int g_coord_width      = 12
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [3:0]                      host_a_i,
    input  logic [31:0]                     host_d_i,
    output logic [31:0]                     host_d_o,
    input  logic                            host_wr_i,
    output logic                            fifo_empty_o,
    input  logic                            fifo_rd_i,
    output logic [24*g_pixels_per_clock-1:0] fifo_pixels_o,
    output logic                            pix_vsync_o,
    input  logic                            pix_next_frame_i,
    output logic                            test_en_o
);

    localparam int P  = g_pixels_per_clock;
    localparam int CW = g_coord_width;

    logic [CW-1:0]   r_xsize;
    logic [CW-1:0]   r_ysize;
    logic [9:0]      r_ctl;
    logic [23:0]     r_color;
    logic [31:0]     r_host_d;

    logic [CW-1:0]   r_s_xsize;
    logic [CW-1:0]   r_s_ysize;
    logic [2:0]      r_s_mode;
    logic [3:0]      r_s_shift;
    logic            r_s_border;
    logic [23:0]     r_s_color;

    state_t          r_state;
    logic [CW-1:0]   r_xcnt;
    logic [CW-1:0]   r_ycnt;
    logic [CW-1:0]   r_offset;
    logic [15:0]     r_frame_cnt;
    logic            r_vsync;
    logic            r_empty;
    logic [24*P-1:0] r_pixels;

    logic [CW-1:0]   w_lane_x [P];
    logic [CW-1:0]   w_lane_xs [P];
    logic [24*P-1:0] w_beat;
    logic            w_line_end;
    logic            w_frame_end;
    logic            w_dis;
    logic [31:0]     w_rd;
    logic            w_unused_d;

    assign w_unused_d = &{1'b0, host_d_i[31:24]};

    for (genvar k = 0; k < P; k++) begin : g_lane
        assign w_lane_x[k]  = r_xcnt * CW'(P) + CW'(k);
        assign w_lane_xs[k] = w_lane_x[k] + r_offset;
        dsi_pattern_pixel #(
            .g_coord_width(CW)
        ) u_pix (
            .i_xs       (w_lane_xs[k]),
            .i_x        (w_lane_x[k]),
            .i_y        (r_ycnt),
            .i_xsize    (r_s_xsize),
            .i_ysize    (r_s_ysize),
            .i_mode     (r_s_mode),
            .i_bar_shift(r_s_shift),
            .i_border_en(r_s_border),
            .i_color    (r_s_color),
            .o_rgb      (w_beat[24*k +: 24])
        );
    end

    assign w_line_end  = w_lane_x[P-1] == r_s_xsize;
    assign w_frame_end = w_line_end && r_ycnt == r_s_ysize;
    assign w_dis       = host_wr_i && host_a_i == REG_TEST_CTL && !host_d_i[0];

    always_comb begin
        w_rd = host_a_i == REG_TEST_XSIZE  ? 32'(r_xsize) :
               host_a_i == REG_TEST_YSIZE  ? 32'(r_ysize) :
               host_a_i == REG_TEST_CTL    ? {22'd0, r_ctl} :
               host_a_i == REG_TEST_COLOR  ? {8'd0, r_color} :
               host_a_i == REG_TEST_STATUS ? {14'd0, r_state, r_frame_cnt} : 32'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_xsize  <= '0;
            r_ysize  <= '0;
            r_ctl    <= '0;
            r_color  <= '0;
            r_host_d <= '0;
        end else begin
            r_host_d <= w_rd;
            if (host_wr_i && host_a_i == REG_TEST_XSIZE) r_xsize <= host_d_i[CW-1:0];
            if (host_wr_i && host_a_i == REG_TEST_YSIZE) r_ysize <= host_d_i[CW-1:0];
            if (host_wr_i && host_a_i == REG_TEST_CTL) r_ctl <= host_d_i[9:0];
            if (host_wr_i && host_a_i == REG_TEST_COLOR) r_color <= host_d_i[23:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_xcnt      <= '0;
            r_ycnt      <= '0;
            r_offset    <= '0;
            r_frame_cnt <= '0;
            r_vsync     <= 1'b0;
            r_empty     <= 1'b0;
            r_pixels    <= '0;
            r_s_xsize   <= '0;
            r_s_ysize   <= '0;
            r_s_mode    <= '0;
            r_s_shift   <= '0;
            r_s_border  <= 1'b0;
            r_s_color   <= '0;
        end else if (w_dis) begin
            r_state  <= ST_IDLE;
            r_vsync  <= 1'b0;
            r_empty  <= 1'b1;
            r_pixels <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_empty <= 1'b1;
                    if (r_ctl[0]) begin
                        r_xcnt  <= '0;
                        r_ycnt  <= '0;
                        r_state <= ST_WAIT_NEXT_FRAME;
                    end
                end
                ST_WAIT_NEXT_FRAME: begin
                    if (pix_next_frame_i) begin
                        r_vsync    <= 1'b1;
                        r_s_xsize  <= r_xsize;
                        r_s_ysize  <= r_ysize;
                        r_s_mode   <= r_ctl[3:1];
                        r_s_shift  <= r_ctl[7:4];
                        r_s_border <= r_ctl[8];
                        r_s_color  <= r_color;
                        r_state    <= ST_VSYNC;
                    end
                end
                ST_VSYNC: begin
                    if (!pix_next_frame_i) begin
                        r_vsync <= 1'b0;
                        r_empty <= 1'b0;
                        r_state <= ST_IMAGE;
                    end
                end
                ST_IMAGE: begin
                    if (fifo_rd_i) begin
                        r_pixels <= w_beat;
                        if (w_frame_end) begin
                            r_xcnt      <= '0;
                            r_ycnt      <= '0;
                            r_empty     <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_offset    <= r_ctl[9] ? r_offset + CW'(1) : '0;
                            r_state     <= ST_WAIT_NEXT_FRAME;
                        end else if (w_line_end) begin
                            r_xcnt <= '0;
                            r_ycnt <= r_ycnt + CW'(1);
                        end else begin
                            r_xcnt <= r_xcnt + CW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host_d_o      = r_host_d;
    assign fifo_empty_o  = r_empty;
    assign fifo_pixels_o = r_pixels;
    assign pix_vsync_o   = r_vsync;
    assign test_en_o     = r_ctl[0];

endmodule

// File: tb/tb_dsi_pattern_gen.sv
// tb_dsi_pattern_gen: directed, table-driven and random frame checks against a coordinate-level image model
module tb_dsi_pattern_gen;
    import dsi_pattern_gen_pkg::*;

    localparam int P = 2;

    typedef struct {
        int          xsize;
        int          ysize;
        int          mode;
        int          bs;
        int          border;
        int          scroll;
        logic [23:0] color;
    } cfg_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } reg_vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      host_a = '0;
    logic [31:0]     host_d = '0;
    logic [31:0]     host_q;
    logic            host_wr = 1'b0;
    logic            empty;
    logic            fifo_rd = 1'b0;
    logic [24*P-1:0] pixels;
    logic            vsync;
    logic            nf = 1'b0;
    logic            test_en;

    int checks = 0;
    int failures = 0;
    int fc = 0;
    int off = 0;
    logic [24*P-1:0] got [$];
    logic [23:0] bars [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                              24'h00FFFF, 24'hFF00FF, 24'h808080, 24'h000000};

    dsi_pattern_gen #(.g_pixels_per_clock(P), .g_coord_width(12)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .host_a_i        (host_a),
        .host_d_i        (host_d),
        .host_d_o        (host_q),
        .host_wr_i       (host_wr),
        .fifo_empty_o    (empty),
        .fifo_rd_i       (fifo_rd),
        .fifo_pixels_o   (pixels),
        .pix_vsync_o     (vsync),
        .pix_next_frame_i(nf),
        .test_en_o       (test_en)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] g, input logic [63:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, g, e);
        end
    endtask

    function automatic logic [23:0] model_px(input int x, input int y, input cfg_t c, input int o);
        int xs;
        logic [7:0] v;
        xs = (x + o) % 4096;
        if (c.border != 0 && (x == 0 || y == 0 || x == c.xsize || y == c.ysize)) return 24'hFFFFFF;
        case (c.mode)
            0: return bars[(xs >> c.bs) % 8];
            1: begin v = 8'(xs % 256); return {v, v, v}; end
            2: begin v = 8'(y % 256); return {v, v, v}; end
            3: return ((((xs >> c.bs) ^ (y >> c.bs)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            4: return c.color;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        host_a = a; host_d = d; host_wr = 1'b1;
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        host_a = a;
        @(negedge clk);
        v = host_q;
    endtask

    task automatic cfg_write(input cfg_t c);
        wr(REG_TEST_XSIZE, 32'(c.xsize));
        wr(REG_TEST_YSIZE, 32'(c.ysize));
        wr(REG_TEST_COLOR, {8'd0, c.color});
        wr(REG_TEST_CTL, 32'(1 + c.mode * 2 + c.bs * 16 + c.border * 256 + c.scroll * 512));
    endtask

    task automatic start_frame();
        int n;
        nf = 1'b1;
        n = 0;
        while (vsync !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("vsync_high", 64'(vsync), 64'd1);
        nf = 1'b0;
        n = 0;
        while (empty !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("image_entered", 64'(empty), 64'd0);
        check("vsync_low", 64'(vsync), 64'd0);
    endtask

    task automatic beat(output logic [24*P-1:0] v);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        v = pixels;
    endtask

    task automatic run_frame(input cfg_t c, input int wr_at, input int new_xsize);
        int l, nb, gaps;
        logic [24*P-1:0] e, prev;
        logic [31:0] s;
        start_frame();
        l = (c.xsize + 1) / P;
        nb = l * (c.ysize + 1);
        got.delete();
        prev = '0;
        for (int b = 0; b < nb; b++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) @(negedge clk);
            if (b > 0 && gaps > 0) check("hold", 64'(pixels), 64'(prev));
            fifo_rd = 1'b1;
            if (b == wr_at) begin
                host_a = REG_TEST_XSIZE; host_d = 32'(new_xsize); host_wr = 1'b1;
            end
            @(negedge clk);
            fifo_rd = 1'b0;
            host_wr = 1'b0;
            for (int k = 0; k < P; k++) e[24*k +: 24] = model_px((b % l) * P + k, b / l, c, off);
            check("beat", 64'(pixels), 64'(e));
            got.push_back(pixels);
            prev = e;
        end
        check("empty_after_frame", 64'(empty), 64'd1);
        fc++;
        off = c.scroll != 0 ? (off + 1) % 4096 : 0;
        rd(REG_TEST_STATUS, s);
        check("status", 64'(s), 64'(32'(fc % 65536) + 32'h0001_0000));
    endtask

    initial begin
        reg_vec_t rv [6];
        logic [24*P-1:0] t1 [6];
        logic [24*P-1:0] t2 [4];
        logic [24*P-1:0] v;
        logic [31:0] q;
        cfg_t c;

        rv[0] = '{REG_TEST_CTL,    32'hFFFF_FC3E, 32'h0000_003E};
        rv[1] = '{REG_TEST_XSIZE,  32'hABCD_E123, 32'h0000_0123};
        rv[2] = '{REG_TEST_YSIZE,  32'h0000_0456, 32'h0000_0456};
        rv[3] = '{REG_TEST_COLOR,  32'hAB12_3456, 32'h0012_3456};
        rv[4] = '{4'h7,            32'hDEAD_BEEF, 32'h0000_0000};
        rv[5] = '{4'hF,            32'hFFFF_FFFF, 32'h0000_0000};
        t1 = '{48'hFFFFFF_FFFFFF, 48'hFFFFFF_FFFFFF, 48'hFF0000_FFFFFF,
               48'hFFFFFF_FF0000, 48'hFFFFFF_FFFFFF, 48'hFFFFFF_FFFFFF};
        t2 = '{48'h010101_000000, 48'h030303_020202, 48'h050505_040404, 48'h070707_060606};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_pixels", 64'(pixels), 64'd0);
        check("rst_empty", 64'(empty), 64'd0);
        check("rst_vsync", 64'(vsync), 64'd0);
        check("rst_test_en", 64'(test_en), 64'd0);
        check("rst_host_d", 64'(host_q), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_empty", 64'(empty), 64'd1);

        // register table
        for (int i = 0; i < 6; i++) begin
            wr(rv[i].a, rv[i].d);
            rd(rv[i].a, q);
            check("reg_readback", 64'(q), 64'(rv[i].exp));
        end
        wr(REG_TEST_STATUS, 32'hFFFF_FFFF);
        rd(REG_TEST_STATUS, q);
        check("status_idle", 64'(q), 64'd0);

        // bars with border, bar_shift 2
        c = '{3, 2, 0, 2, 1, 0, 24'h0};
        cfg_write(c);
        run_frame(c, -1, 0);
        for (int i = 0; i < 6; i++) check("t1_beat", 64'(got[i]), 64'(t1[i]));
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        check("rd_ignored_pixels", 64'(pixels), 64'(t1[5]));
        check("rd_ignored_empty", 64'(empty), 64'd1);

        // horizontal ramp, one line
        c = '{7, 0, 1, 0, 0, 0, 24'h0};
        cfg_write(c);
        run_frame(c, -1, 0);
        for (int i = 0; i < 4; i++) check("t2_beat", 64'(got[i]), 64'(t2[i]));

        // scrolling bars over two frames
        c = '{3, 0, 0, 1, 0, 1, 24'h0};
        cfg_write(c);
        run_frame(c, -1, 0);
        check("scroll_f1_x0", 64'(got[0][23:0]), 64'h00FF0000);
        run_frame(c, -1, 0);
        check("scroll_f2", 64'(got[0]), 64'h00FF00_FF0000);

        // mid-frame XSIZE write, simultaneous with a beat
        c = '{3, 1, 1, 0, 1, 0, 24'h0};
        cfg_write(c);
        run_frame(c, 1, 15);
        c.xsize = 15;
        run_frame(c, -1, 0);

        // enable clear mid-image
        c = '{5, 2, 4, 0, 0, 0, 24'hA5A5A5};
        cfg_write(c);
        start_frame();
        beat(v);
        check("pre_dis_beat", 64'(v), 64'hA5A5A5_A5A5A5);
        wr(REG_TEST_CTL, 32'd0);
        check("dis_empty", 64'(empty), 64'd1);
        check("dis_pixels", 64'(pixels), 64'd0);
        check("dis_test_en", 64'(test_en), 64'd0);
        check("dis_vsync", 64'(vsync), 64'd0);
        rd(REG_TEST_STATUS, q);
        check("dis_state", 64'(q[17:16]), 64'd0);

        // asynchronous reset mid-frame
        cfg_write(c);
        start_frame();
        beat(v);
        host_a = REG_TEST_CTL;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_pixels", 64'(pixels), 64'd0);
        check("arst_empty", 64'(empty), 64'd0);
        check("arst_vsync", 64'(vsync), 64'd0);
        check("arst_test_en", 64'(test_en), 64'd0);
        check("arst_host_d", 64'(host_q), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fc = 0;
        off = 0;
        @(negedge clk);
        check("post_rst_empty", 64'(empty), 64'd1);

        // solid colour and readback
        c = '{3, 1, 4, 0, 0, 0, 24'h123456};
        cfg_write(c);
        rd(REG_TEST_CTL, q);
        check("ctl_readback", 64'(q), 64'h9);
        rd(REG_TEST_COLOR, q);
        check("color_readback", 64'(q), 64'h123456);
        run_frame(c, -1, 0);
        check("solid_beat", 64'(got[0]), 64'h123456_123456);

        // random frames
        for (int f = 0; f < 12; f++) begin
            c.xsize  = P * $urandom_range(1, 5) - 1;
            c.ysize  = $urandom_range(0, 3);
            c.mode   = $urandom_range(0, 7);
            c.bs     = $urandom_range(0, 3);
            c.border = $urandom_range(0, 1);
            c.scroll = $urandom_range(0, 1);
            c.color  = 24'($urandom);
            cfg_write(c);
            run_frame(c, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
